// File: rtl/ms_alarm.sv
// Millisecond compare/alarm block: NUM_CH one-shot or periodic channels matched against the RTC count.
// Register reads are registered (1-cycle latency); irq_o is the OR of pending-and-enabled channels.
module ms_alarm #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              tick_i,
   input  logic [31:0]       millis_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              we_i,
   input  logic              re_i,
   output logic [31:0]       rdata_o,
   output logic              irq_o
);

   localparam int CH_W = ADDR_W - 2;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } ch_state_t;

   ch_state_t   state_q  [NUM_CH];
   ch_state_t   state_d  [NUM_CH];
   logic        per_q    [NUM_CH];
   logic        per_d    [NUM_CH];
   logic        ie_q     [NUM_CH];
   logic        ie_d     [NUM_CH];
   logic        pend_q   [NUM_CH];
   logic        pend_d   [NUM_CH];
   logic        ovr_q    [NUM_CH];
   logic        ovr_d    [NUM_CH];
   logic [31:0] cmp_q    [NUM_CH];
   logic [31:0] cmp_d    [NUM_CH];
   logic [31:0] period_q [NUM_CH];
   logic [31:0] period_d [NUM_CH];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   logic [CH_W-1:0] ch_sel;
   logic [1:0]      off;

   assign ch_sel = addr_i[ADDR_W-1:2];
   assign off    = addr_i[1:0];

   always_comb begin
      logic wr_sel;
      logic hit;
      logic clr_pend;
      logic clr_ovr;
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c]  = state_q[c];
         per_d[c]    = per_q[c];
         ie_d[c]     = ie_q[c];
         pend_d[c]   = pend_q[c];
         ovr_d[c]    = ovr_q[c];
         cmp_d[c]    = cmp_q[c];
         period_d[c] = period_q[c];

         wr_sel   = we_i && (ch_sel == CH_W'(c));
         hit      = (state_q[c] == ARMED) && tick_i && (millis_i == cmp_q[c]);
         clr_pend = wr_sel && (off == 2'd3) && wdata_i[0];
         clr_ovr  = wr_sel && (off == 2'd3) && wdata_i[1];

         if (clr_pend) pend_d[c] = 1'b0;
         if (clr_ovr)  ovr_d[c]  = 1'b0;

         // Match is applied first so a same-cycle register write overrides it.
         if (hit) begin
            pend_d[c] = 1'b1;
            if (pend_q[c] && !clr_pend) ovr_d[c] = 1'b1;
            if (per_q[c] && (period_q[c] != 32'd0))
               cmp_d[c] = cmp_q[c] + period_q[c];
            else
               state_d[c] = IDLE;
         end

         if (wr_sel) begin
            case (off)
               2'd0: begin
                  state_d[c] = wdata_i[0] ? ARMED : IDLE;
                  per_d[c]   = wdata_i[1];
                  ie_d[c]    = wdata_i[2];
               end
               2'd1:    cmp_d[c]    = wdata_i;
               2'd2:    period_d[c] = wdata_i;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      logic [31:0] rd_val;
      rd_val = 32'd0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel == CH_W'(c)) begin
            case (off)
               2'd0:    rd_val = {29'd0, ie_q[c], per_q[c], state_q[c] == ARMED};
               2'd1:    rd_val = cmp_q[c];
               2'd2:    rd_val = period_q[c];
               default: rd_val = {30'd0, ovr_q[c], pend_q[c]};
            endcase
         end
      end
      rdata_d = re_i ? rd_val : rdata_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c]  <= IDLE;
            per_q[c]    <= 1'b0;
            ie_q[c]     <= 1'b0;
            pend_q[c]   <= 1'b0;
            ovr_q[c]    <= 1'b0;
            cmp_q[c]    <= 32'd0;
            period_q[c] <= 32'd0;
         end
         rdata_q <= 32'd0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c]  <= state_d[c];
            per_q[c]    <= per_d[c];
            ie_q[c]     <= ie_d[c];
            pend_q[c]   <= pend_d[c];
            ovr_q[c]    <= ovr_d[c];
            cmp_q[c]    <= cmp_d[c];
            period_q[c] <= period_d[c];
         end
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

   always_comb begin
      irq_o = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         irq_o = irq_o | (pend_q[c] & ie_q[c]);
   end

endmodule

// File: tb/tb_ms_alarm.sv
// Bench for ms_alarm: directed scenarios then random traffic against a transaction-level model.
module tb_ms_alarm;
   localparam int NUM_CH = 2;
   localparam int ADDR_W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_i = 1'b0;
   logic [31:0] millis_i = 32'd0;
   logic [3:0]  addr_i = 4'd0;
   logic [31:0] wdata_i = 32'd0;
   logic        we_i = 1'b0;
   logic        re_i = 1'b0;
   logic [31:0] rdata_o;
   logic        irq_o;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   // Model: one record per channel holding the architecturally visible register fields.
   bit          m_en[NUM_CH], m_per[NUM_CH], m_ie[NUM_CH], m_pend[NUM_CH], m_ovr[NUM_CH];
   logic [31:0] m_cmp[NUM_CH], m_period[NUM_CH];

   ms_alarm #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk), .rst_i(rst), .tick_i(tick_i), .millis_i(millis_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i), .re_i(re_i),
      .rdata_o(rdata_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
         m_cmp[c] = 32'd0; m_period[c] = 32'd0;
      end
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] a);
      int c = int'(a[3:2]);
      if (c >= NUM_CH) return 32'd0;
      case (a[1:0])
         2'd0:    return {29'd0, m_ie[c], m_per[c], m_en[c]};
         2'd1:    return m_cmp[c];
         2'd2:    return m_period[c];
         default: return {30'd0, m_ovr[c], m_pend[c]};
      endcase
   endfunction

   function automatic bit m_irq();
      bit r = 0;
      for (int c = 0; c < NUM_CH; c++) r |= m_pend[c] & m_ie[c];
      return r;
   endfunction

   // One clock of the model: alarm event first, then the CPU write takes effect on top.
   function automatic void m_cycle(input bit tk, input logic [31:0] ms, input bit w,
                                   input logic [3:0] a, input logic [31:0] wd);
      for (int c = 0; c < NUM_CH; c++) begin
         bit hit   = m_en[c] && tk && (ms == m_cmp[c]);
         bit mine  = w && (int'(a[3:2]) == c);
         bit clr_p = mine && (a[1:0] == 2'd3) && wd[0];
         bit clr_o = mine && (a[1:0] == 2'd3) && wd[1];
         bit was_p = m_pend[c];
         if (clr_p) m_pend[c] = 0;
         if (clr_o) m_ovr[c] = 0;
         if (hit) begin
            if (was_p && !clr_p) m_ovr[c] = 1;
            m_pend[c] = 1;
            if (m_per[c] && m_period[c] != 0) m_cmp[c] = m_cmp[c] + m_period[c];
            else m_en[c] = 0;
         end
         if (mine) begin
            case (a[1:0])
               2'd0: begin m_en[c] = wd[0]; m_per[c] = wd[1]; m_ie[c] = wd[2]; end
               2'd1: m_cmp[c] = wd;
               2'd2: m_period[c] = wd;
               default: ;
            endcase
         end
      end
   endfunction

   // Drive one cycle from a negedge; expected read data goes to the scoreboard queue.
   task automatic cyc(input bit tk, input logic [31:0] ms, input bit w, input logic [3:0] a,
                      input logic [31:0] wd, input bit r, input bit use_c, input logic [31:0] cval);
      tick_i = tk; millis_i = ms; we_i = w; addr_i = a; wdata_i = wd; re_i = r;
      if (r) exp_q.push_back(use_c ? cval : m_read(a));
      m_cycle(tk, ms, w, a, wd);
      @(negedge clk);
      chk("irq", {31'd0, irq_o}, {31'd0, m_irq()});
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cyc(0, millis_i, 1, a, d, 0, 0, 0);
   endtask
   task automatic tk(input logic [31:0] ms);
      cyc(1, ms, 0, 4'd0, 0, 0, 0, 0);
   endtask
   task automatic rdc(input logic [3:0] a, input logic [31:0] e);
      cyc(0, millis_i, 0, a, 0, 1, 1, e);
   endtask
   task automatic idle();
      cyc(0, millis_i, 0, 4'd0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted between edges, with a tick that must be lost.
   task automatic pulse_reset(input logic [31:0] ms);
      tick_i = 1; millis_i = ms; we_i = 0; re_i = 0;
      #2 rst = 1;
      #1 chk("irq_async_rst", {31'd0, irq_o}, 32'd0);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 0; tick_i = 0;
   endtask

   // Monitor: every accepted read strobe is checked one edge later.
   always @(posedge clk) begin
      if (re_i && !rst) begin
         #1;
         if (exp_q.size() == 0) begin
            chk("rd_underflow", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("rdata", rdata_o, mon_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] mcount;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_irq", {31'd0, irq_o}, 32'd0);
      chk("reset_rdata", rdata_o, 32'd0);
      rst = 0;

      // Force irq high, then reset and check every channel register.
      wr(4'd1, 32'd5); wr(4'd0, 32'd5); tk(32'd5);
      chk("pre_reset_irq", {31'd0, irq_o}, 32'd1);
      pulse_reset(32'd5);
      for (int a = 0; a < 8; a++) rdc(4'(a), 32'd0);

      // Ch0 one-shot.
      wr(4'd1, 32'd100); wr(4'd0, 32'b101); tk(32'd100);
      chk("oneshot_irq", {31'd0, irq_o}, 32'd1);
      rdc(4'd3, 32'd1); rdc(4'd0, 32'd4);
      wr(4'd3, 32'd1);
      chk("w1c_irq", {31'd0, irq_o}, 32'd0);

      // Ch1 periodic, no clearing between matches.
      wr(4'd5, 32'd10); wr(4'd6, 32'd5); wr(4'd4, 32'b111);
      tk(32'd10); idle(); tk(32'd15); idle(); tk(32'd20);
      rdc(4'd5, 32'd25); rdc(4'd7, 32'd3); rdc(4'd4, 32'd7);
      wr(4'd7, 32'd3); wr(4'd4, 32'd0);

      // Counter wrap.
      wr(4'd5, 32'hFFFF_FFFE); wr(4'd6, 32'd4); wr(4'd4, 32'b111);
      tk(32'hFFFF_FFFE);
      rdc(4'd5, 32'h0000_0002);
      wr(4'd7, 32'd3); tk(32'd2);
      rdc(4'd7, 32'd1); rdc(4'd5, 32'd6);
      wr(4'd4, 32'd0); wr(4'd7, 32'd3);

      // Same-cycle W1C vs match, then CMP write vs periodic reload.
      wr(4'd1, 32'd40); wr(4'd2, 32'd10); wr(4'd0, 32'b111); tk(32'd40);
      cyc(1, 32'd50, 1, 4'd3, 32'd1, 0, 0, 0);
      rdc(4'd3, 32'd1);
      cyc(1, 32'd60, 1, 4'd1, 32'd200, 0, 0, 0);
      rdc(4'd1, 32'd200); rdc(4'd3, 32'd3);

      // Reset while armed and pending; old compare value must not fire afterwards.
      chk("armed_irq", {31'd0, irq_o}, 32'd1);
      pulse_reset(32'd200);
      tk(32'd200);
      rdc(4'd3, 32'd0); rdc(4'd0, 32'd0);

      // Random traffic near the live compare values, crossing the 32-bit wrap.
      mcount = 32'hFFFF_FFF0;
      for (int i = 0; i < 3000; i++) begin
         bit          t  = ($urandom_range(0, 3) == 0);
         bit          w  = ($urandom_range(0, 2) == 0);
         bit          r  = ($urandom_range(0, 2) == 0);
         logic [3:0]  a  = 4'($urandom_range(0, 15));
         logic [31:0] d;
         case (a[1:0])
            2'd0:    d = 32'($urandom_range(0, 7));
            2'd1:    d = mcount + 32'($urandom_range(0, 6));
            2'd2:    d = 32'($urandom_range(0, 4));
            default: d = 32'($urandom_range(0, 3));
         endcase
         if (t) mcount = mcount + 1;
         cyc(t, mcount, w, a, d, r, 0, 0);
      end

      idle(); idle();
      chk("rd_drain", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ms_alarm.md
Name: ms_alarm

Overview:
- Millisecond alarm/compare peripheral sitting directly downstream of the RTC.
- Consumes the RTC 1 ms tick pulse and 32-bit millisecond count.
- Provides NUM_CH independent compare channels (one-shot or periodic) behind a simple CPU register port.
- Drives a single level interrupt to the core.

Parameters:
- NUM_CH, 2, number of compare channels (1..4).
- ADDR_W, 4, word-address width of register port; channel c occupies words 4c..4c+3.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- tick_i  in  1  one-cycle 1 ms pulse from RTC; millis_i already holds the incremented value in that cycle.
- millis_i  in  32  current millisecond count from RTC.
- addr_i  in  ADDR_W  register word address.
- wdata_i  in  32  write data.
- we_i  in  1  write strobe, one cycle per write.
- re_i  in  1  read strobe.
- rdata_o  out  32  read data, registered.
- irq_o  out  1  level interrupt = OR over channels of (PEND & IE).

Behaviour:
- Clock and reset: one clock clk_i; rst_i is asynchronous and active-high.
- Reset values: all registers 0, all channels IDLE, rdata_o=0, irq_o=0.
- Register map, per channel, offset from 4c:
  - +0 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IE.
  - +1 CMP (RW, 32 bit): absolute match time in ms.
  - +2 PERIOD (RW, 32 bit).
  - +3 STATUS: read bit0 PEND, bit1 OVR; write 1 to clear each bit.
- Unmapped addresses, and channels >= NUM_CH, read 0; writes to them are ignored.
- Reads: rdata_o is updated on the edge after re_i (1-cycle latency) and holds until the next read. Reads have no side effects.
- Channel FSM:
  - IDLE: EN=0; a CTRL write with EN=1 -> ARMED.
  - ARMED: match = tick_i && (millis_i == CMP). Compare happens only in tick cycles.
    - On match: PEND<=1.
    - Periodic with PERIOD!=0: CMP <= CMP + PERIOD (mod 2^32, wrap allowed); stay ARMED.
    - Otherwise (one-shot, or PERIOD==0): EN auto-clears -> IDLE.
  - A CTRL write with EN=0 in any state -> IDLE. PEND/OVR are preserved.
- Match in a cycle where PEND is already 1 and not being cleared: OVR<=1.
- PEND/OVR/CMP update on the edge ending the tick cycle. irq_o reflects them combinationally from flops, so irq_o rises 1 cycle after tick_i.
- Simultaneous events:
  - W1C of PEND in the same cycle as a match: set wins; PEND stays 1, OVR not set.
  - CMP write in the same cycle as a match: match uses the old CMP; the written value wins over the periodic reload.
  - CTRL write in the same cycle as a match: match is processed, then the CTRL value is applied, overriding any auto-clear.
- Clearing IE masks irq_o immediately without touching PEND.
- millis_i wrap 0xFFFFFFFF->0: no special case; CMP=0 matches on the wrap tick.
- Reset asserted mid-operation: all state returns to reset values asynchronously; ticks during reset are lost.

Test Plan:
- Reset with irq_o forced high beforehand -> irq_o=0 and all 8 channel registers read 0.
- Ch0: CMP=100, CTRL=0b101, tick with millis_i=100 -> PEND=1 one cycle later, irq_o=1, CTRL reads 0b100; W1C STATUS=1 -> irq_o=0.
- Ch1 periodic: CMP=10, PERIOD=5, CTRL=0b111, ticks 10,15,20 -> three matches, CMP reads 25; skipping W1C between matches sets OVR=1.
- Wrap: periodic CMP=0xFFFFFFFE, PERIOD=4 -> after match CMP reads 0x00000002; match fires at millis_i=2.
- Simultaneous W1C and match at millis_i=50 -> PEND stays 1, OVR stays 0. Simultaneous CMP write 200 with periodic match -> CMP reads 200.
- Reset pulse while ch0 ARMED and PEND=1 -> irq_o drops asynchronously, and a later tick at the old CMP produces no match.
